// File: rtl/paddle_input.sv
// paddle_input
// Turns the four raw player buttons into registered paddle centre rows.
// Each button is synchronised and debounced, a shared tick paces movement,
// a small per-player FSM adds acceleration after a long hold, and every
// candidate position is clamped to the playfield for the current bat size.
// Player 2 can instead follow the ball for practice/demo play.

module paddle_input #(
   parameter int Y_MIN     = 31,
   parameter int Y_MAX     = 449,
   parameter int Y_CENTER  = 240,
   parameter int DB_CYCLES = 500000,
   parameter int STEP_DIV  = 32768
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p1_up,
   input  logic        p1_dn,
   input  logic        p2_up,
   input  logic        p2_dn,
   input  logic        bat_size,
   input  logic        auto_p2,
   input  logic [10:0] ball_y,
   input  logic        recenter,
   output logic [10:0] p1_y,
   output logic [10:0] p2_y
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SLOW = 2'd1,
      FAST = 2'd2
   } move_state_t;

   // Button bit order everywhere: {p2_dn, p2_up, p1_dn, p1_up}
   logic [3:0]         sync1;
   logic [3:0]         sync2;
   logic [3:0]         db_level;
   logic [19:0]        db_cnt [4];

   logic [15:0]        tick_cnt;
   logic               tick;

   logic [10:0]        half;
   logic [10:0]        lo;
   logic [10:0]        hi;

   logic signed [1:0]  dir      [2];
   move_state_t        state    [2];
   move_state_t        state_n  [2];
   logic signed [1:0]  last_dir [2];
   logic signed [1:0]  last_n   [2];
   logic [3:0]         run_cnt  [2];
   logic [3:0]         run_n    [2];
   logic signed [11:0] step     [2];
   logic signed [11:0] cand     [2];
   logic [10:0]        y_q      [2];
   logic [10:0]        y_n      [2];

   // Maps the debounced up/down pair of one player to a signed direction;
   // pressing both or neither means no movement.
   function automatic logic signed [1:0] dir_of(input logic up, input logic dn);
      if (up && !dn) begin
         return 2'sb11;
      end else if (dn && !up) begin
         return 2'sb01;
      end else begin
         return 2'sb00;
      end
   endfunction

   // Two-flop synchroniser for the asynchronous button inputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {p2_dn, p2_up, p1_dn, p1_up};
         sync2 <= sync1;
      end
   end

   // Debounce: a level change is accepted only after it has been stable
   // for DB_CYCLES consecutive cycles; any bounce back resets the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_level <= '0;
         for (int b = 0; b < 4; b++) begin
            db_cnt[b] <= '0;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (sync2[b] == db_level[b]) begin
               db_cnt[b] <= '0;
            end else if (db_cnt[b] == 20'(DB_CYCLES - 1)) begin
               db_level[b] <= ~db_level[b];
               db_cnt[b]   <= '0;
            end else begin
               db_cnt[b] <= db_cnt[b] + 20'd1;
            end
         end
      end
   end

   assign tick = (tick_cnt == 16'(STEP_DIV - 1));

   // Free-running movement pacer shared by both players; recenter leaves it alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end

   // Playfield limits for the paddle centre depend on the current bat height.
   always_comb begin
      half = bat_size ? 11'd19 : 11'd29;
      lo   = 11'(Y_MIN) + half;
      hi   = 11'(Y_MAX) - half;
      dir[0] = dir_of(db_level[0], db_level[1]);
      dir[1] = dir_of(db_level[2], db_level[3]);
   end

   // Next-state logic for both players: FSM/acceleration on tick, ball
   // tracking for player 2 in auto mode, recenter overriding everything,
   // then a clamp that runs every cycle so bat-size changes take effect at once.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         state_n[p] = state[p];
         last_n[p]  = last_dir[p];
         run_n[p]   = run_cnt[p];
         step[p]    = 12'sd0;
         cand[p]    = 12'sd0;
         y_n[p]     = y_q[p];

         if (recenter) begin
            state_n[p] = IDLE;
            last_n[p]  = 2'sb00;
            run_n[p]   = 4'd0;
         end else if (p == 1 && auto_p2) begin
            state_n[p] = IDLE;
            last_n[p]  = 2'sb00;
            run_n[p]   = 4'd0;
            if (tick) begin
               if ({1'b0, ball_y} > ({1'b0, y_q[p]} + 12'd2)) begin
                  step[p] = 12'sd1;
               end else if ({1'b0, y_q[p]} > ({1'b0, ball_y} + 12'd2)) begin
                  step[p] = -12'sd1;
               end
            end
         end else if (tick) begin
            case (state[p])
               IDLE: begin
                  if (dir[p] != 2'sb00) begin
                     state_n[p] = SLOW;
                     last_n[p]  = dir[p];
                     run_n[p]   = 4'd1;
                     step[p]    = {{10{dir[p][1]}}, dir[p]};
                  end
               end
               SLOW, FAST: begin
                  if (dir[p] == 2'sb00) begin
                     state_n[p] = IDLE;
                     run_n[p]   = 4'd0;
                  end else if (dir[p] != last_dir[p]) begin
                     state_n[p] = SLOW;
                     last_n[p]  = dir[p];
                     run_n[p]   = 4'd1;
                     step[p]    = {{10{dir[p][1]}}, dir[p]};
                  end else if (state[p] == FAST) begin
                     step[p]    = {{9{dir[p][1]}}, dir[p], 1'b0};
                  end else begin
                     step[p]    = {{10{dir[p][1]}}, dir[p]};
                     run_n[p]   = run_cnt[p] + 4'd1;
                     if (run_cnt[p] + 4'd1 == 4'd15) begin
                        state_n[p] = FAST;
                     end
                  end
               end
               default: begin
                  state_n[p] = IDLE;
                  run_n[p]   = 4'd0;
               end
            endcase
         end

         if (recenter) begin
            cand[p] = 12'(Y_CENTER);
         end else begin
            cand[p] = $signed({1'b0, y_q[p]}) + step[p];
         end

         if (cand[p] < $signed({1'b0, lo})) begin
            y_n[p] = lo;
         end else if (cand[p] > $signed({1'b0, hi})) begin
            y_n[p] = hi;
         end else begin
            y_n[p] = cand[p][10:0];
         end
      end
   end

   // Paddle positions and per-player FSM registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int p = 0; p < 2; p++) begin
            y_q[p]      <= 11'(Y_CENTER);
            state[p]    <= IDLE;
            last_dir[p] <= 2'sb00;
            run_cnt[p]  <= 4'd0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            y_q[p]      <= y_n[p];
            state[p]    <= state_n[p];
            last_dir[p] <= last_n[p];
            run_cnt[p]  <= run_n[p];
         end
      end
   end

   assign p1_y = y_q[0];
   assign p2_y = y_q[1];

endmodule

// File: tb/tb_paddle_input.sv
// tb_paddle_input
// Directed bench for paddle_input with short debounce (4) and tick (8)
// periods. Edges are counted from reset release, so with a button held
// through reset the debounced level flips at edge 6 and moves land on
// edges 8, 16, 24, ...

module tb_paddle_input;

   logic        clk;
   logic        rst;
   logic        p1_up;
   logic        p1_dn;
   logic        p2_up;
   logic        p2_dn;
   logic        bat_size;
   logic        auto_p2;
   logic [10:0] ball_y;
   logic        recenter;
   logic [10:0] p1_y;
   logic [10:0] p2_y;

   int assertCount = 0;
   int failCount   = 0;
   int cyc         = 0;

   paddle_input #(
      .DB_CYCLES (4),
      .STEP_DIV  (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .p1_up    (p1_up),
      .p1_dn    (p1_dn),
      .p2_up    (p2_up),
      .p2_dn    (p2_dn),
      .bat_size (bat_size),
      .auto_p2  (auto_p2),
      .ball_y   (ball_y),
      .recenter (recenter),
      .p1_y     (p1_y),
      .p2_y     (p2_y)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [10:0] observed,
                              input logic [10:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic u1, input logic d1,
                                input logic u2, input logic d2);
      p1_up = u1;
      p1_dn = d1;
      p2_up = u2;
      p2_dn = d2;
   endtask

   task automatic holdReset();
      @(negedge clk);
      rst      = 1'b0;
      recenter = 1'b0;
   endtask

   task automatic releaseReset();
      repeat (3) @(negedge clk);
      checkOutput("reset_p1", p1_y, 11'd240);
      checkOutput("reset_p2", p2_y, 11'd240);
      rst = 1'b1;
      cyc = 0;
   endtask

   // Advance to just after edge number 'target' counted from reset release.
   task automatic stepTo(input int target);
      while (cyc < target) begin
         @(posedge clk);
         cyc++;
      end
      #1;
   endtask

   initial begin
      rst      = 1'b0;
      bat_size = 1'b0;
      auto_p2  = 1'b0;
      ball_y   = 11'd0;
      recenter = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      // p1_dn held from reset: slow steps, then acceleration on step 16
      holdReset();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      releaseReset();
      stepTo(7);   checkOutput("dn_before_tick", p1_y, 11'd240);
      stepTo(8);   checkOutput("dn_step1", p1_y, 11'd241);
      stepTo(112); checkOutput("dn_step14", p1_y, 11'd254);
      stepTo(120); checkOutput("dn_step15", p1_y, 11'd255);
      stepTo(127); checkOutput("dn_hold_between", p1_y, 11'd255);
      stepTo(128); checkOutput("dn_fast16", p1_y, 11'd257);
      stepTo(136); checkOutput("dn_fast17", p1_y, 11'd259);
      checkOutput("dn_p2_idle", p2_y, 11'd240);

      // Short glitch on p1_up must never be accepted
      holdReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      releaseReset();
      stepTo(20);
      p1_up = 1'b1;
      stepTo(22);
      p1_up = 1'b0;
      stepTo(30);  checkOutput("glitch_30", p1_y, 11'd240);
      stepTo(100); checkOutput("glitch_100", p1_y, 11'd240);

      // p2_up held: saturate at top for large bat, then small bat, then back
      holdReset();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      releaseReset();
      stepTo(120); checkOutput("up_step15", p2_y, 11'd225);
      stepTo(128); checkOutput("up_fast16", p2_y, 11'd223);
      stepTo(899); checkOutput("up_sat_large", p2_y, 11'd60);
      bat_size = 1'b1;
      stepTo(900); checkOutput("up_small_nomove", p2_y, 11'd60);
      stepTo(904); checkOutput("up_small_tick", p2_y, 11'd58);
      stepTo(1000); checkOutput("up_sat_small", p2_y, 11'd50);
      bat_size = 1'b0;
      stepTo(1001); checkOutput("up_pull_inside", p2_y, 11'd60);
      checkOutput("up_p1_idle", p1_y, 11'd240);

      // Both p1 buttons held: no motion, FSM idle so first move is a single step
      holdReset();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      releaseReset();
      stepTo(200); checkOutput("both_held", p1_y, 11'd240);
      p1_up = 1'b0;
      stepTo(207); checkOutput("both_release_wait", p1_y, 11'd240);
      stepTo(208); checkOutput("both_first_step", p1_y, 11'd241);
      stepTo(216); checkOutput("both_second_step", p1_y, 11'd242);

      // Auto-tracking of player 2 toward ball_y=400 with buttons toggling
      holdReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      auto_p2 = 1'b1;
      ball_y  = 11'd400;
      releaseReset();
      for (int c = 1; c <= 1400; c++) begin
         if (c % 40 == 0) p2_up = ~p2_up;
         if (c % 60 == 0) p2_dn = ~p2_dn;
         stepTo(c);
         if (c == 8)    checkOutput("auto_step1", p2_y, 11'd241);
         if (c == 80)   checkOutput("auto_step10", p2_y, 11'd250);
         if (c == 1256) checkOutput("auto_397", p2_y, 11'd397);
         if (c == 1264) checkOutput("auto_398", p2_y, 11'd398);
         if (c == 1400) checkOutput("auto_hold", p2_y, 11'd398);
      end
      checkOutput("auto_p1_idle", p1_y, 11'd240);
      auto_p2 = 1'b0;

      // Recenter while FAST, then asynchronous reset mid-move
      holdReset();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      releaseReset();
      stepTo(296); checkOutput("rc_fast_p1", p1_y, 11'd299);
      checkOutput("rc_fast_p2", p2_y, 11'd299);
      recenter = 1'b1;
      stepTo(297);
      recenter = 1'b0;
      checkOutput("rc_p1_center", p1_y, 11'd240);
      checkOutput("rc_p2_center", p2_y, 11'd240);
      stepTo(303); checkOutput("rc_wait", p1_y, 11'd240);
      stepTo(304); checkOutput("rc_slow1", p1_y, 11'd241);
      stepTo(312); checkOutput("rc_slow2", p1_y, 11'd242);
      stepTo(320); checkOutput("rc_slow3", p1_y, 11'd243);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_rst_p1", p1_y, 11'd240);
      checkOutput("async_rst_p2", p2_y, 11'd240);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
